// File: rtl/mips_mdu_pkg.sv
// Shared MDU control codes and FSM state type for the multiply/divide unit
// and the ALU control decoder that produces the codes.
package mips_mdu_pkg;

    localparam int MDU_CTRL_W = 3;

    localparam logic [MDU_CTRL_W-1:0] MDU_MULT  = 3'b100;
    localparam logic [MDU_CTRL_W-1:0] MDU_MULTU = 3'b101;
    localparam logic [MDU_CTRL_W-1:0] MDU_DIV   = 3'b110;
    localparam logic [MDU_CTRL_W-1:0] MDU_DIVU  = 3'b111;
    localparam logic [MDU_CTRL_W-1:0] MDU_MTHI  = 3'b001;
    localparam logic [MDU_CTRL_W-1:0] MDU_MTLO  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mips_mdu_if.sv
// Request/result bundle between the execute stage (master) and the MDU (slave).
interface mips_mdu_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int MDU_CTRL_WIDTH = 3
);
    logic                      i_start;
    logic [MDU_CTRL_WIDTH-1:0] i_mdu_ctrl;
    logic [DATA_WIDTH-1:0]     i_rs;
    logic [DATA_WIDTH-1:0]     i_rt;
    logic [DATA_WIDTH-1:0]     o_hi;
    logic [DATA_WIDTH-1:0]     o_lo;
    logic                      o_busy;
    logic                      o_done;
    logic                      o_div_zero;
    logic                      o_wrong_instr;

    modport master (
        output i_start, i_mdu_ctrl, i_rs, i_rt,
        input  o_hi, o_lo, o_busy, o_done, o_div_zero, o_wrong_instr
    );

    modport slave (
        input  i_start, i_mdu_ctrl, i_rs, i_rt,
        output o_hi, o_lo, o_busy, o_done, o_div_zero, o_wrong_instr
    );
endinterface

// File: rtl/mips_mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, sharing one accumulator/low-word register pair.
module mips_mdu_iter_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_init,
    input  logic                    i_step,
    input  logic                    i_is_div,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic                    o_last,
    output logic [2*DATA_WIDTH-1:0] o_prod,
    output logic [DATA_WIDTH-1:0]   o_quot,
    output logic [DATA_WIDTH-1:0]   o_rem
);

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;

    // acc holds the product high word (multiply) or the partial remainder (divide);
    // the extra bit of sum/shifted/diff carries the overflow/borrow.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q, lo_q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (i_init) begin
            cnt_d = '0;
            acc_d = '0;
            lo_d  = i_a;
            b_d   = i_b;
        end else if (i_step) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (i_is_div) begin
                if (!diff[DATA_WIDTH]) begin
                    acc_d = diff[DATA_WIDTH-1:0];
                    lo_d  = {lo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[DATA_WIDTH-1:0];
                    lo_d  = {lo_q[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = sum[DATA_WIDTH:1];
                lo_d  = {sum[0], lo_q[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            b_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
        end
    end

    assign o_last = i_step && (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
    assign o_prod = {acc_q, lo_q};
    assign o_quot = lo_q;
    assign o_rem  = acc_q;

endmodule

// File: rtl/mips_mdu.sv
// Multiply/divide unit: IDLE/CALC/FIX sequencing, sign handling and the
// architectural HI/LO pair; iterations are delegated to mips_mdu_iter_core.
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MDU_CTRL_WIDTH = MDU_CTRL_W,
    parameter int CNT_WIDTH      = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mips_mdu_if.slave   bus
);

    mdu_state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                      neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
    logic                      is_div_q, is_div_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic                      div_zero_q, div_zero_d, wrong_q, wrong_d;
    logic [MDU_CTRL_WIDTH-1:0] ctrl;
    logic                      signed_op, is_div_op, a_neg, b_neg;
    logic [DATA_WIDTH-1:0]     a_abs, b_abs;
    logic                      core_init, core_step, core_last;
    logic [2*DATA_WIDTH-1:0]   core_prod, prod_fix;
    logic [DATA_WIDTH-1:0]     core_quot, core_rem, quot_fix, rem_fix;

    assign ctrl      = bus.i_mdu_ctrl;
    assign signed_op = (ctrl == MDU_MULT) || (ctrl == MDU_DIV);
    assign is_div_op = (ctrl == MDU_DIV) || (ctrl == MDU_DIVU);
    assign a_neg     = signed_op & bus.i_rs[DATA_WIDTH-1];
    assign b_neg     = signed_op & bus.i_rt[DATA_WIDTH-1];
    assign a_abs     = a_neg ? -bus.i_rs : bus.i_rs;
    assign b_abs     = b_neg ? -bus.i_rt : bus.i_rt;
    assign core_step = (state_q == ST_CALC);

    // Negating 0x80000000 yields itself, which gives the MIPS overflow result for free.
    assign prod_fix = neg_quot_q ? -core_prod : core_prod;
    assign quot_fix = neg_quot_q ? -core_quot : core_quot;
    assign rem_fix  = neg_rem_q  ? -core_rem  : core_rem;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_div_d   = is_div_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        wrong_d    = 1'b0;
        core_init  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    case (ctrl)
                        MDU_MTHI: begin
                            hi_d   = bus.i_rs;
                            done_d = 1'b1;
                        end
                        MDU_MTLO: begin
                            lo_d   = bus.i_rs;
                            done_d = 1'b1;
                        end
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            if (is_div_op && (bus.i_rt == '0)) begin
                                done_d     = 1'b1;
                                div_zero_d = 1'b1;
                            end else begin
                                core_init  = 1'b1;
                                neg_quot_d = a_neg ^ b_neg;
                                neg_rem_d  = a_neg;
                                is_div_d   = is_div_op;
                                state_d    = ST_CALC;
                            end
                        end
                        default: wrong_d = 1'b1;
                    endcase
                end
            end
            ST_CALC: begin
                if (core_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            wrong_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            is_div_q   <= is_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            wrong_q    <= wrong_d;
        end
    end

    mips_mdu_iter_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_init   (core_init),
        .i_step   (core_step),
        .i_is_div (is_div_q),
        .i_a      (a_abs),
        .i_b      (b_abs),
        .o_last   (core_last),
        .o_prod   (core_prod),
        .o_quot   (core_quot),
        .o_rem    (core_rem)
    );

    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_div_zero    = div_zero_q;
    assign bus.o_wrong_instr = wrong_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed + randomized bench for mips_mdu against an arithmetic HI/LO model.
module tb_mips_mdu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mips_mdu_if #(.DATA_WIDTH(32), .MDU_CTRL_WIDTH(3)) bus ();

    mips_mdu #(.DATA_WIDTH(32), .MDU_CTRL_WIDTH(3), .CNT_WIDTH(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the ISA definition using 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            3'b100: res = sa * sb;
            3'b101: res = {32'd0, a} * {32'd0, b};
            3'b110: begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: res = {a % b, a / b};
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input string tag);
        logic [63:0] exp;
        logic        dz, md, held_bad;
        int          n, busy_n;
        md = c[2];
        dz = (c == 3'b110 || c == 3'b111) && (b == 32'd0);
        if (md && !dz)       exp = ref_md(c, a, b);
        else if (c == 3'b001) exp = {a, exp_lo};
        else if (c == 3'b011) exp = {exp_hi, a};
        else                 exp = {exp_hi, exp_lo};
        bus.i_start    = 1'b1;
        bus.i_mdu_ctrl = c;
        bus.i_rs       = a;
        bus.i_rt       = b;
        tick();
        bus.i_start = 1'b0;
        bus.i_rs    = $urandom;
        bus.i_rt    = $urandom;
        if (md && !dz) begin
            n = 0;
            busy_n = 0;
            held_bad = 1'b0;
            while (!bus.o_done && n < 60) begin
                busy_n += int'(bus.o_busy);
                if ({bus.o_hi, bus.o_lo} !== {exp_hi, exp_lo}) held_bad = 1'b1;
                bus.i_start    = (n == poke_at);
                bus.i_mdu_ctrl = 3'($urandom_range(0, 7));
                tick();
                n++;
            end
            bus.i_start = 1'b0;
            chk({tag, "_latency"}, 64'(n), 64'd33);
            chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
            chk({tag, "_hold_old"}, {63'd0, held_bad}, 64'd0);
        end
        chk({tag, "_done"}, {63'd0, bus.o_done}, 64'd1);
        chk({tag, "_busy_at_done"}, {63'd0, bus.o_busy}, 64'd0);
        chk({tag, "_div_zero"}, {63'd0, bus.o_div_zero}, {63'd0, dz});
        chk({tag, "_hilo"}, {bus.o_hi, bus.o_lo}, exp);
        exp_hi = exp[63:32];
        exp_lo = exp[31:0];
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a, b;
        logic        saw_done;
        int          r;

        bus.i_start = 1'b0;
        bus.i_mdu_ctrl = '0;
        bus.i_rs = '0;
        bus.i_rt = '0;
        repeat (3) tick();
        chk("reset_outputs", {bus.o_hi, bus.o_lo}, 64'd0);
        chk("reset_flags", {60'd0, bus.o_busy, bus.o_done, bus.o_div_zero, bus.o_wrong_instr}, 64'd0);
        rst = 1'b0;
        tick();

        run_op(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "multu_max");
        chk("multu_max_const", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFE_00000001);
        tick();
        chk("multu_done_pulse", {62'd0, bus.o_done, bus.o_busy}, 64'd0);

        run_op(3'b100, 32'hFFFFFFFD, 32'd7, -1, "mult_neg");
        chk("mult_neg_const", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, -1, "div_neg");
        chk("div_neg_const", {bus.o_hi, bus.o_lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(3'b111, 32'd100, 32'd0, -1, "divu_zero");
        tick();
        chk("div_zero_pulse", {62'd0, bus.o_done, bus.o_div_zero}, 64'd0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, -1, "div_ovf");
        chk("div_ovf_const", {bus.o_hi, bus.o_lo}, 64'h00000000_80000000);

        run_op(3'b001, 32'h12345678, 32'd0, -1, "mthi");
        run_op(3'b011, 32'h9ABCDEF0, 32'd0, -1, "mtlo");
        chk("mt_const", {bus.o_hi, bus.o_lo}, 64'h12345678_9ABCDEF0);

        for (int i = 0; i < 2; i++) begin
            bus.i_start = 1'b1;
            bus.i_mdu_ctrl = (i == 0) ? 3'b010 : 3'b000;
            bus.i_rs = $urandom;
            tick();
            bus.i_start = 1'b0;
            chk("wrong_pulse", {61'd0, bus.o_wrong_instr, bus.o_done, bus.o_busy}, 64'd4);
            chk("wrong_hilo_kept", {bus.o_hi, bus.o_lo}, {exp_hi, exp_lo});
            tick();
            chk("wrong_pulse_clear", {63'd0, bus.o_wrong_instr}, 64'd0);
        end

        run_op(3'b111, 32'd100, 32'd7, 4, "divu_poke");
        chk("divu_poke_const", {bus.o_hi, bus.o_lo}, {32'd2, 32'd14});
        run_op(3'b101, 32'd123456, 32'd654321, -1, "back_to_back");

        bus.i_start = 1'b1;
        bus.i_mdu_ctrl = 3'b100;
        bus.i_rs = 32'd55;
        bus.i_rt = 32'hFFFFFF00;
        tick();
        bus.i_start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {63'd0, bus.o_busy}, 64'd0);
        chk("rst_mid_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.o_done) saw_done = 1'b1;
            tick();
        end
        chk("rst_mid_no_done", {63'd0, saw_done}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                4: c = 3'b001;
                5: c = 3'b011;
                default: c = 3'(4 + r);
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run_op(c, a, b, (i % 3 == 0) ? int'($urandom_range(0, 30)) : -1, "rand");
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
